// File: rtl/sm_mult_pkg.sv
// sm_mult_pkg: shared constants, rounding-mode encodings and helpers for the sign-magnitude multiplier
package sm_mult_pkg;
  localparam int STAGES_MIN = 1;
  localparam int STAGES_MAX = 3;
  typedef enum logic {RND_TRUNC = 1'b0, RND_HALF_UP = 1'b1} rnd_e;
  function automatic longint unsigned sm_max_mag(input int n);
    return (64'd1 << (n - 1)) - 64'd1;
  endfunction
endpackage

// File: rtl/sm_round_sat.sv
// sm_round_sat: rounding, magnitude saturation and -0 cleanup of a full-width sign-magnitude product
module sm_round_sat
  import sm_mult_pkg::*;
#(
  parameter int N = 16,
  parameter int FRAC = 15
) (
  input  logic [2*N-3:0] p,
  input  logic           s,
  input  logic           rnd_mode,
  output logic [N-1:0]   c,
  output logic           ovf
);
  localparam int PW = 2 * (N - 1) + 1;
  localparam logic [PW-1:0] HALF = PW'(1) << (FRAC - 1);
  localparam logic [PW-1:0] MAX = PW'(sm_max_mag(N));
  logic [PW-1:0] m;
  logic [N-2:0] mag;
  // one spare top bit keeps the rounding add from wrapping
  assign m = ({1'b0, p} + (rnd_mode == RND_HALF_UP ? HALF : '0)) >> FRAC;
  assign ovf = m > MAX;
  assign mag = ovf ? MAX[N-2:0] : m[N-2:0];
  assign c = {s && (|mag), mag};
endmodule

// File: rtl/sm_mult_pipe.sv
// sm_mult_pipe: pipelined sign-magnitude fixed-point multiplier with valid/ready backpressure.
// Optional SM_MULT_OVF_STICKY_EN adds ovf_clr / ovf_sticky.
module sm_mult_pipe
  import sm_mult_pkg::*;
#(
  parameter int N = 16,
  parameter int FRAC = 15,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         rnd_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] c,
  output logic         ovf
`ifdef SM_MULT_OVF_STICKY_EN
  ,
  input  logic         ovf_clr,
  output logic         ovf_sticky
`endif
);
  localparam int MW = N - 1;
  logic en;
  logic v1, s1, r1;
  logic [MW-1:0] am1, bm1;
  logic v2, s2, r2;
  logic [2*MW-1:0] p2;
  logic [N-1:0] c_nxt;
  logic ovf_nxt;
  // a single global enable freezes every stage, bubbles included
  assign en = !out_valid || out_ready;
  assign in_ready = en;
  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad
    $error("sm_mult_pipe: STAGES must be 1, 2 or 3");
  end
  if (STAGES == 3) begin : g_in
    always_ff @(posedge clk)
      if (rst) v1 <= 1'b0;
      else if (en) begin
        v1 <= in_valid;
        s1 <= a[N-1] ^ b[N-1];
        r1 <= rnd_mode;
        am1 <= a[N-2:0];
        bm1 <= b[N-2:0];
      end
  end else begin : g_in_pass
    assign v1 = in_valid;
    assign s1 = a[N-1] ^ b[N-1];
    assign r1 = rnd_mode;
    assign am1 = a[N-2:0];
    assign bm1 = b[N-2:0];
  end
  if (STAGES >= 2) begin : g_prod
    always_ff @(posedge clk)
      if (rst) v2 <= 1'b0;
      else if (en) begin
        v2 <= v1;
        s2 <= s1;
        r2 <= r1;
        p2 <= am1 * bm1;
      end
  end else begin : g_prod_pass
    assign v2 = v1;
    assign s2 = s1;
    assign r2 = r1;
    assign p2 = am1 * bm1;
  end
  sm_round_sat #(.N(N), .FRAC(FRAC)) u_round_sat (
    .p(p2),
    .s(s2),
    .rnd_mode(r2),
    .c(c_nxt),
    .ovf(ovf_nxt)
  );
  always_ff @(posedge clk)
    if (rst) begin
      out_valid <= 1'b0;
      c <= '0;
      ovf <= 1'b0;
    end else if (en) begin
      out_valid <= v2;
      c <= c_nxt;
      ovf <= ovf_nxt;
    end
`ifdef SM_MULT_OVF_STICKY_EN
  always_ff @(posedge clk)
    if (rst) ovf_sticky <= 1'b0;
    else if (out_valid && out_ready && ovf) ovf_sticky <= 1'b1;
    else if (ovf_clr) ovf_sticky <= 1'b0;
`endif
endmodule

// File: tb/tb_sm_mult_pipe.sv
// tb_sm_mult_pipe: directed vector bench for sm_mult_pipe across STAGES 1/2/3 and FRAC 15/8
module tb_sm_mult_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic rnd = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic ir1, ir2, ir8, ir3, ov1, ov2, ov8, ov3, of1, of2, of8, of3;
  logic [15:0] c1, c2, c8, c3;
`ifdef SM_MULT_OVF_STICKY_EN
  logic ovf_clr = 1'b0;
  logic st1, st2, st8, st3;
`endif
  int checks = 0, errors = 0;
  always #5 clk = ~clk;

  sm_mult_pipe #(.N(16), .FRAC(15), .STAGES(1)) u1 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1),
    .a(a), .b(b), .rnd_mode(rnd), .out_valid(ov1), .out_ready(out_ready), .c(c1), .ovf(of1)
`ifdef SM_MULT_OVF_STICKY_EN
    , .ovf_clr(ovf_clr), .ovf_sticky(st1)
`endif
  );
  sm_mult_pipe #(.N(16), .FRAC(15), .STAGES(2)) u2 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2),
    .a(a), .b(b), .rnd_mode(rnd), .out_valid(ov2), .out_ready(out_ready), .c(c2), .ovf(of2)
`ifdef SM_MULT_OVF_STICKY_EN
    , .ovf_clr(ovf_clr), .ovf_sticky(st2)
`endif
  );
  sm_mult_pipe #(.N(16), .FRAC(8), .STAGES(2)) u8 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir8),
    .a(a), .b(b), .rnd_mode(rnd), .out_valid(ov8), .out_ready(out_ready), .c(c8), .ovf(of8)
`ifdef SM_MULT_OVF_STICKY_EN
    , .ovf_clr(ovf_clr), .ovf_sticky(st8)
`endif
  );
  sm_mult_pipe #(.N(16), .FRAC(15), .STAGES(3)) u3 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir3),
    .a(a), .b(b), .rnd_mode(rnd), .out_valid(ov3), .out_ready(out_ready), .c(c3), .ovf(of3)
`ifdef SM_MULT_OVF_STICKY_EN
    , .ovf_clr(ovf_clr), .ovf_sticky(st3)
`endif
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic rnd;
    logic f8;
    logic [15:0] c;
    logic ovf;
  } vec_t;
  localparam int NV = 19;
  vec_t tv[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    int sent, got, cyc, extra;
    logic prev_stall;
    logic [15:0] held;
    tv[0]  = '{16'h4000, 16'h4000, 1'b0, 1'b0, 16'h2000, 1'b0};
    tv[1]  = '{16'hC000, 16'h4000, 1'b0, 1'b0, 16'hA000, 1'b0};
    tv[2]  = '{16'h0001, 16'h4000, 1'b0, 1'b0, 16'h0000, 1'b0};
    tv[3]  = '{16'h0001, 16'h4000, 1'b1, 1'b0, 16'h0001, 1'b0};
    tv[4]  = '{16'h8001, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0};
    tv[5]  = '{16'h8000, 16'h7FFF, 1'b0, 1'b0, 16'h0000, 1'b0};
    tv[6]  = '{16'h8001, 16'h4000, 1'b1, 1'b0, 16'h8001, 1'b0};
    tv[7]  = '{16'h7FFF, 16'h7FFF, 1'b1, 1'b0, 16'h7FFE, 1'b0};
    tv[8]  = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'h7FFE, 1'b0};
    tv[9]  = '{16'h8000, 16'h8000, 1'b1, 1'b0, 16'h0000, 1'b0};
    tv[10] = '{16'h7FFF, 16'h7FFF, 1'b0, 1'b1, 16'h7FFF, 1'b1};
    tv[11] = '{16'hFFFF, 16'h7FFF, 1'b0, 1'b1, 16'hFFFF, 1'b1};
    tv[12] = '{16'h0100, 16'h0100, 1'b0, 1'b1, 16'h0100, 1'b0};
    tv[13] = '{16'h7FFF, 16'h0100, 1'b0, 1'b1, 16'h7FFF, 1'b0};
    tv[14] = '{16'h7FFF, 16'h0101, 1'b0, 1'b1, 16'h7FFF, 1'b1};
    tv[15] = '{16'h012C, 16'h6D3A, 1'b0, 1'b1, 16'h7FFF, 1'b0};
    tv[16] = '{16'h812C, 16'h6D3A, 1'b1, 1'b1, 16'hFFFF, 1'b1};
    tv[17] = '{16'h8001, 16'h0080, 1'b0, 1'b1, 16'h0000, 1'b0};
    tv[18] = '{16'h8001, 16'h0080, 1'b1, 1'b1, 16'h8001, 1'b0};

    repeat (2) @(negedge clk);
    chk("rst_out_valid", ov2, 0);
    chk("rst_c", c2, 0);
    chk("rst_ovf", of2, 0);
    chk("rst_in_ready", ir2, 1);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      a = tv[i].a;
      b = tv[i].b;
      rnd = tv[i].rnd;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      if (!tv[i].f8) begin
        chk($sformatf("v%0d_s1_valid", i), ov1, 1);
        chk($sformatf("v%0d_s1_c", i), c1, tv[i].c);
        chk($sformatf("v%0d_s1_ovf", i), of1, tv[i].ovf);
      end
      chk($sformatf("v%0d_s2_early", i), ov2, 0);
      @(negedge clk);
      if (tv[i].f8) begin
        chk($sformatf("v%0d_f8_valid", i), ov8, 1);
        chk($sformatf("v%0d_f8_c", i), c8, tv[i].c);
        chk($sformatf("v%0d_f8_ovf", i), of8, tv[i].ovf);
      end else begin
        chk($sformatf("v%0d_s2_valid", i), ov2, 1);
        chk($sformatf("v%0d_s2_c", i), c2, tv[i].c);
        chk($sformatf("v%0d_s2_ovf", i), of2, tv[i].ovf);
      end
      @(negedge clk);
      if (!tv[i].f8) begin
        chk($sformatf("v%0d_s3_valid", i), ov3, 1);
        chk($sformatf("v%0d_s3_c", i), c3, tv[i].c);
      end
    end
    @(negedge clk);

`ifdef SM_MULT_OVF_STICKY_EN
    chk("sticky_f8_set", st8, 1);
    chk("sticky_f15_clear", st2, 0);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("sticky_cleared", st8, 0);
    ovf_clr = 1'b1;
    a = 16'h7FFF;
    b = 16'h7FFF;
    rnd = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("sticky_set_wins", st8, 1);
    @(negedge clk);
    chk("sticky_clr_after", st8, 0);
    ovf_clr = 1'b0;
    repeat (2) @(negedge clk);
`endif

    sent = 0;
    got = 0;
    cyc = 0;
    prev_stall = 1'b0;
    held = '0;
    b = 16'h4000;
    rnd = 1'b0;
    while (got < 8 && cyc < 60) begin
      in_valid = (sent < 8);
      a = 16'((sent + 1) << 11);
      out_ready = !(cyc >= 5 && cyc < 9);
      #1;
      if (!out_ready) begin
        chk($sformatf("bp_in_ready_c%0d", cyc), ir3, 0);
        chk($sformatf("bp_valid_c%0d", cyc), ov3, 1);
        if (prev_stall) chk($sformatf("bp_hold_c%0d", cyc), c3, held);
        held = c3;
      end
      prev_stall = !out_ready;
      if (ov3 && out_ready) begin
        chk($sformatf("bp_res%0d", got), c3, 16'((got + 1) << 10));
        got++;
      end
      if (in_valid && ir3) sent++;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp_count", got, 8);
    extra = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ov3) extra++;
    end
    chk("bp_no_dup", extra, 0);

    a = 16'h4000;
    b = 16'h4000;
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    chk("mid_inflight", ov2, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_valid", ov2, 0);
    chk("mid_rst_c", c2, 0);
    extra = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (ov2 || ov3 || ov8 || ov1) extra++;
    end
    chk("mid_no_stale", extra, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
